// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and the MEM/WB pipeline register.
//   mem_state_e       : MEM-stage access FSM state (IDLE=0, WAIT=1)
//   DATA_W_DEF        : default data/address width
//   REG_W_DEF         : default register-index width
//   BUBBLE_*          : control values loaded into MEM/WB when a bubble is inserted
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic BUBBLE_REG_WRITE  = 1'b0;
  localparam logic BUBBLE_MEM_TO_REG = 1'b0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline bundle register with bubble insertion.
// Loads the bundle every cycle; when bubble=1 the writeback controls are
// forced to their bubble values so the slot retires without side effects.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   bubble                : force writeback controls inactive this edge
//   *_d                   : bundle to be registered
//   *_q                   : registered bundle toward WB
module mem_wb_reg
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [DATA_W-1:0] pc_next_d,
  input  logic [DATA_W-1:0] alu_result_d,
  input  logic [DATA_W-1:0] read_data_d,
  input  logic              mem_to_reg_d,
  input  logic              reg_write_d,
  input  logic [REG_W-1:0]  write_register_d,
  output logic [DATA_W-1:0] pc_next_q,
  output logic [DATA_W-1:0] alu_result_q,
  output logic [DATA_W-1:0] read_data_q,
  output logic              mem_to_reg_q,
  output logic              reg_write_q,
  output logic [REG_W-1:0]  write_register_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_next_q        <= '0;
      alu_result_q     <= '0;
      read_data_q      <= '0;
      mem_to_reg_q     <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
    end else begin
      pc_next_q        <= pc_next_d;
      alu_result_q     <= alu_result_d;
      read_data_q      <= read_data_d;
      write_register_q <= write_register_d;
      if (bubble) begin
        mem_to_reg_q <= BUBBLE_MEM_TO_REG;
        reg_write_q  <= BUBBLE_REG_WRITE;
      end else begin
        mem_to_reg_q <= mem_to_reg_d;
        reg_write_q  <= reg_write_d;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage MIPS pipeline.
// Issues data-memory accesses over a req/ack handshake, stalls upstream while
// an access is outstanding (bounded by MAX_WAIT), resolves branch/jump
// redirect and registers the MEM/WB bundle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   *_MEM inputs               : EX/MEM bundle (address, store data, controls)
//   dmem_req/we/addr/wdata     : registered memory request
//   dmem_ack/rdata             : memory completion pulse and read data
//   stall_MEM                  : freeze PC, IF/ID, ID/EX, EX/MEM
//   PCSrc_MEM                  : take redirect this cycle
//   *_WB outputs               : registered MEM/WB bundle
//   mem_err                    : sticky error (read+write together, or timeout)
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] PC_next_MEM,
  input  logic [DATA_W-1:0] ALU_result_MEM,
  input  logic [DATA_W-1:0] Read_Data_2_MEM,
  input  logic              Branch_MEM,
  input  logic              Jump_MEM,
  input  logic              Zero_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              MemToReg_MEM,
  input  logic              RegWrite_MEM,
  input  logic [REG_W-1:0]  Write_register_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_MEM,
  output logic              PCSrc_MEM,
  output logic [DATA_W-1:0] PC_next_WB,
  output logic [DATA_W-1:0] ALU_result_WB,
  output logic [DATA_W-1:0] Read_data_WB,
  output logic              MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  Write_register_WB,
  output logic              mem_err
);

  localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  mem_state_e        state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              access;
  logic              issue;
  logic              finish;
  logic              timeout;
  logic              timeout_err;
  logic              wb_bubble;
  logic [DATA_W-1:0] read_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    access      = MemRead_MEM | MemWrite_MEM;
    state_next  = state;
    issue       = 1'b0;
    finish      = 1'b0;
    timeout     = 1'b0;
    timeout_err = 1'b0;
    stall_MEM   = 1'b0;
    wb_bubble   = 1'b0;
    read_data_d = '0;
    case (state)
      IDLE: begin
        if (access) begin
          issue      = 1'b1;
          stall_MEM  = 1'b1;
          wb_bubble  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        timeout = (wait_cnt == CNT_MAX);
        if (dmem_ack || timeout) begin
          finish     = 1'b1;
          state_next = IDLE;
          // An ack landing on the timeout cycle still counts as a completion.
          timeout_err = timeout & ~dmem_ack;
          if (dmem_ack && !dmem_we) read_data_d = dmem_rdata;
        end else begin
          stall_MEM = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    PCSrc_MEM = ((Branch_MEM & Zero_MEM) | Jump_MEM) & ~stall_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wait_cnt   <= '0;
      mem_err    <= 1'b0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite_MEM;
      dmem_addr  <= ALU_result_MEM;
      dmem_wdata <= Read_Data_2_MEM;
      wait_cnt   <= '0;
      if (MemRead_MEM && MemWrite_MEM) mem_err <= 1'b1;
    end else if (finish) begin
      dmem_req <= 1'b0;
      if (timeout_err) mem_err <= 1'b1;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .bubble           (wb_bubble),
    .pc_next_d        (PC_next_MEM),
    .alu_result_d     (ALU_result_MEM),
    .read_data_d      (read_data_d),
    .mem_to_reg_d     (MemToReg_MEM),
    .reg_write_d      (RegWrite_MEM),
    .write_register_d (Write_register_MEM),
    .pc_next_q        (PC_next_WB),
    .alu_result_q     (ALU_result_WB),
    .read_data_q      (Read_data_WB),
    .mem_to_reg_q     (MemToReg_WB),
    .reg_write_q      (RegWrite_WB),
    .write_register_q (Write_register_WB)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int MW = 15;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] PC_next_MEM, ALU_result_MEM, Read_Data_2_MEM;
  logic          Branch_MEM, Jump_MEM, Zero_MEM;
  logic          MemRead_MEM, MemWrite_MEM, MemToReg_MEM, RegWrite_MEM;
  logic [RW-1:0] Write_register_MEM;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          stall_MEM, PCSrc_MEM;
  logic [DW-1:0] PC_next_WB, ALU_result_WB, Read_data_WB;
  logic          MemToReg_WB, RegWrite_WB;
  logic [RW-1:0] Write_register_WB;
  logic          mem_err;

  int checks   = 0;
  int failures = 0;

  mem_stage_ctrl #(
    .DATA_W   (DW),
    .REG_W    (RW),
    .MAX_WAIT (MW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .PC_next_MEM        (PC_next_MEM),
    .ALU_result_MEM     (ALU_result_MEM),
    .Read_Data_2_MEM    (Read_Data_2_MEM),
    .Branch_MEM         (Branch_MEM),
    .Jump_MEM           (Jump_MEM),
    .Zero_MEM           (Zero_MEM),
    .MemRead_MEM        (MemRead_MEM),
    .MemWrite_MEM       (MemWrite_MEM),
    .MemToReg_MEM       (MemToReg_MEM),
    .RegWrite_MEM       (RegWrite_MEM),
    .Write_register_MEM (Write_register_MEM),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .stall_MEM          (stall_MEM),
    .PCSrc_MEM          (PCSrc_MEM),
    .PC_next_WB         (PC_next_WB),
    .ALU_result_WB      (ALU_result_WB),
    .Read_data_WB       (Read_data_WB),
    .MemToReg_WB        (MemToReg_WB),
    .RegWrite_WB        (RegWrite_WB),
    .Write_register_WB  (Write_register_WB),
    .mem_err            (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_nop(input logic regw);
    PC_next_MEM        = 32'h0000_1000;
    ALU_result_MEM     = 32'h0000_0011;
    Read_Data_2_MEM    = '0;
    Branch_MEM         = 1'b0;
    Jump_MEM           = 1'b0;
    Zero_MEM           = 1'b0;
    MemRead_MEM        = 1'b0;
    MemWrite_MEM       = 1'b0;
    MemToReg_MEM       = 1'b0;
    RegWrite_MEM       = regw;
    Write_register_MEM = 5'd3;
    dmem_ack           = 1'b0;
  endtask

  // Runs one memory op starting at posedge+1. ack_at = WAIT cycle index
  // (1 = first WAIT cycle) carrying the ack; 0 = never ack.
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_at,
                        input int exp_stall, input logic [31:0] exp_rdata);
    int   c, nst, rw;
    logic done, pcs_bad, pcs_end;
    c = 0; nst = 0; rw = 0; done = 1'b0; pcs_bad = 1'b0; pcs_end = 1'b0;
    PC_next_MEM        = 32'h0000_2000;
    ALU_result_MEM     = addr;
    Read_Data_2_MEM    = wdata;
    Branch_MEM         = 1'b0;
    Jump_MEM           = 1'b1;
    Zero_MEM           = 1'b0;
    MemRead_MEM        = rd;
    MemWrite_MEM       = wr;
    MemToReg_MEM       = rd;
    RegWrite_MEM       = 1'b1;
    Write_register_MEM = 5'd9;
    dmem_rdata         = rdata;
    while (!done && c < MW + 10) begin
      dmem_ack = (ack_at > 0 && c == ack_at);
      #1;
      if (stall_MEM) begin
        nst++;
        if (PCSrc_MEM) pcs_bad = 1'b1;
      end else begin
        done    = 1'b1;
        pcs_end = PCSrc_MEM;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (c == 0) begin
        chk({tag, "_req"}, 32'(dmem_req), 32'd1);
        chk({tag, "_we"},  32'(dmem_we), 32'(wr));
        chk({tag, "_addr"}, dmem_addr, addr);
        if (wr) chk({tag, "_wdata"}, dmem_wdata, wdata);
      end
      if (RegWrite_WB) rw++;
      c++;
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
    chk({tag, "_pcsrc_while_stalled"}, 32'(pcs_bad), 32'd0);
    chk({tag, "_pcsrc_at_leave"}, 32'(pcs_end), 32'd1);
    chk({tag, "_req_dropped"}, 32'(dmem_req), 32'd0);
    chk({tag, "_rdata_wb"}, Read_data_WB, exp_rdata);
    chk({tag, "_regwrite_pulses"}, 32'(rw), 32'd1);
    chk({tag, "_memtoreg_wb"}, 32'(MemToReg_WB), 32'(rd));
    chk({tag, "_wreg_wb"}, 32'(Write_register_WB), 32'd9);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        regw, m2r, br, jmp, zero;
    logic        exp_pcsrc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0000_0004, 32'h0000_0042, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0008, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_000C, 32'h0000_0001, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0010, 32'h0040_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0014, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    dmem_rdata = 32'h5A5A_5A5A;
    set_nop(1'b1);
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_alu_wb", ALU_result_WB, 32'd0);
    chk("rst_regwrite_wb", 32'(RegWrite_WB), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Non-memory ops: zero stall, straight pass-through, redirect decode.
    for (int unsigned i = 0; i < 5; i++) begin
      PC_next_MEM        = vecs[i].pc;
      ALU_result_MEM     = vecs[i].alu;
      Write_register_MEM = vecs[i].wr;
      RegWrite_MEM       = vecs[i].regw;
      MemToReg_MEM       = vecs[i].m2r;
      Branch_MEM         = vecs[i].br;
      Jump_MEM           = vecs[i].jmp;
      Zero_MEM           = vecs[i].zero;
      MemRead_MEM        = 1'b0;
      MemWrite_MEM       = 1'b0;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_MEM), 32'd0);
      chk($sformatf("vec%0d_pcsrc", i), 32'(PCSrc_MEM), 32'(vecs[i].exp_pcsrc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_alu_wb", i), ALU_result_WB, vecs[i].alu);
      chk($sformatf("vec%0d_pc_wb", i), PC_next_WB, vecs[i].pc);
      chk($sformatf("vec%0d_regwrite_wb", i), 32'(RegWrite_WB), 32'(vecs[i].regw));
      chk($sformatf("vec%0d_memtoreg_wb", i), 32'(MemToReg_WB), 32'(vecs[i].m2r));
      chk($sformatf("vec%0d_wreg_wb", i), 32'(Write_register_WB), 32'(vecs[i].wr));
      chk($sformatf("vec%0d_rdata_wb", i), Read_data_WB, 32'd0);
      chk($sformatf("vec%0d_req", i), 32'(dmem_req), 32'd0);
    end

    // Load, ack in 4th WAIT cycle: 4 stall cycles.
    mem_op("load", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4, 4, 32'hDEAD_BEEF);
    set_nop(1'b0);
    @(posedge clk); #1;
    chk("load_regwrite_once", 32'(RegWrite_WB), 32'd0);

    // Store, immediate ack.
    mem_op("store", 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'hCAFE_0000, 1, 1, 32'h0);
    chk("store_no_err", 32'(mem_err), 32'd0);

    // Timeout: never acked; counter runs 0..MW in WAIT.
    mem_op("timeout", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hAAAA_5555, 0, MW + 1, 32'h0);
    chk("timeout_err", 32'(mem_err), 32'd1);
    set_nop(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("err_sticky", 32'(mem_err), 32'd1);

    // Reset in the 2nd WAIT cycle.
    PC_next_MEM    = 32'h0000_3000;
    ALU_result_MEM = 32'h0000_0400;
    MemRead_MEM    = 1'b1;
    RegWrite_MEM   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midwait_req", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_alu_wb", ALU_result_WB, 32'd0);
    chk("arst_pc_wb", PC_next_WB, 32'd0);
    chk("arst_wreg_wb", 32'(Write_register_WB), 32'd0);
    chk("arst_mem_err", 32'(mem_err), 32'd0);
    set_nop(1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_op("post_rst", 1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, 1, 1, 32'h0BAD_F00D);

    // Back-to-back accesses with no idle cycle between.
    mem_op("b2b_st", 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0055, 32'h0, 1, 1, 32'h0);
    mem_op("b2b_ld", 1'b1, 1'b0, 32'h0000_0504, 32'h0, 32'h600D_CAFE, 2, 2, 32'h600D_CAFE);
    chk("b2b_no_err", 32'(mem_err), 32'd0);

    // Read and write together: write only, error flagged.
    mem_op("rdwr", 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0077, 32'hFFFF_0000, 1, 1, 32'h0);
    chk("rdwr_err", 32'(mem_err), 32'd1);

    // Ack in IDLE is ignored.
    set_nop(1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("idle_ack_stall", 32'(stall_MEM), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_rdata", Read_data_WB, 32'd0);
    mem_op("after_idle_ack", 1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'h0000_8888, 1, 1, 32'h0000_8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer of the EX/MEM pipeline-register bundle. Executes the MEM stage of the 5-stage MIPS pipeline.
- Issues data-memory reads and writes over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.
- Resolves branch/jump redirect, and registers the MEM/WB bundle (read data, ALU result, writeback controls) for the WB stage.

Parameters:
- DATA_W, 32, data and address width
- REG_W, 5, register-index width
- MAX_WAIT, 15, max cycles in WAIT before timeout; 1..255

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- PC_next_MEM  in  DATA_W  pass-through PC (unused internally; forwarded to WB)
- ALU_result_MEM  in  DATA_W  memory address / ALU result
- Read_Data_2_MEM  in  DATA_W  store data
- Branch_MEM, Jump_MEM, Zero_MEM  in  1 each  redirect controls
- MemRead_MEM, MemWrite_MEM  in  1 each  access request
- MemToReg_MEM, RegWrite_MEM  in  1 each  writeback controls
- Write_register_MEM  in  REG_W  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  DATA_W  registered address
- dmem_wdata  out  DATA_W  registered write data
- dmem_ack  in  1  completion, single-cycle pulse
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- stall_MEM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- PCSrc_MEM  out  1  take redirect this cycle
- PC_next_WB, ALU_result_WB, Read_data_WB  out  DATA_W each  registered MEM/WB data
- MemToReg_WB, RegWrite_WB  out  1 each  registered MEM/WB controls
- Write_register_WB  out  REG_W  registered destination
- mem_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Every registered output goes to 0, including dmem_req, which drops in the same cycle even mid-access.
  - The wait counter goes to 0 and mem_err clears.
- access = MemRead_MEM | MemWrite_MEM.
- If both MemRead_MEM and MemWrite_MEM are 1: perform a write only and set mem_err.
- FSM states: IDLE, WAIT.
- IDLE:
  - access=0: no stall. The MEM/WB registers load the inputs at the edge; Read_data_WB loads 0.
  - access=1: stall_MEM=1. At the edge, dmem_req<=1, dmem_we<=MemWrite_MEM, dmem_addr<=ALU_result_MEM, dmem_wdata<=Read_Data_2_MEM, counter<=0, go to WAIT. The MEM/WB registers load a bubble (RegWrite_WB=0, MemToReg_WB=0).
- WAIT:
  - stall_MEM = ~dmem_ack & ~timeout, where timeout = (counter==MAX_WAIT).
  - On dmem_ack, or on timeout: at the edge, dmem_req<=0, go to IDLE, and the MEM/WB registers load the inputs.
  - Read_data_WB <= dmem_rdata for a read with ack; 0 for a write or a timeout.
  - A timeout also sets mem_err and still asserts RegWrite_WB as supplied (no hang).
  - Otherwise: counter increments and the MEM/WB registers load a bubble.
- A dmem_ack arriving in IDLE is ignored.
- Minimum memory-op latency is 2 cycles (1 issue cycle plus ack in the first WAIT cycle). Non-memory ops have 0 stall.
- Back-to-back memory ops: the op following a completed access sees IDLE with access=1 and issues on the next edge. No lost or duplicated access.
- PCSrc_MEM = ((Branch_MEM & Zero_MEM) | Jump_MEM) & ~stall_MEM. It is combinational, so the redirect happens only at the edge where the instruction leaves MEM.
- mem_err is sticky; only rst_n clears it.
- Widths are fixed; there is no arithmetic beyond the counter compare. The counter is $clog2(MAX_WAIT+1) bits.

Decomposition:
- Shared package mem_pkg holds:
  - FSM state enum (IDLE=0, WAIT=1)
  - DATA_W and REG_W defaults
  - bubble constants for the MEM/WB controls
- One natural sub-module: mem_wb_reg, the MEM/WB bundle register with a bubble-insert input and async active-low reset. The WB side of the pipeline reuses it.

Test Plan:
- ALU op: RegWrite=1, ALU_result=0x0000_0042, Write_register=5, no access -> next edge ALU_result_WB=0x42, RegWrite_WB=1, Write_register_WB=5, stall_MEM never 1.
- Load, ack 3 cycles after req: addr=0x100, dmem_rdata=0xDEAD_BEEF -> dmem_addr=0x100, stall high for 4 cycles, Read_data_WB=0xDEADBEEF, RegWrite_WB=1 once only.
- Store, immediate ack: addr=0x200, data=0x1234 -> dmem_we=1, dmem_wdata=0x1234, stall high 1 cycle, Read_data_WB=0.
- No ack, MAX_WAIT=15 -> dmem_req drops after 15 WAIT cycles, mem_err=1 and stays 1 through later ops until rst_n.
- rst_n pulsed low in the 2nd WAIT cycle -> dmem_req=0 immediately, all WB outputs 0, state IDLE; a following op issues normally.
- Jump_MEM=1 together with a load -> PCSrc_MEM=0 while stalled, 1 only in the ack cycle.
